// File: rtl/branch_predictor_gshare_if.sv
// branch_predictor_gshare_if: IF/EX-facing predict, update and statistics signals
interface branch_predictor_gshare_if #(
  parameter int GHR_W  = 4,
  parameter int STAT_W = 32
);
  logic              pred_req;
  logic [31:0]       pred_pc;
  logic [31:0]       pred_inst;
  logic              pred_taken;
  logic [31:0]       pred_target;
  logic [GHR_W-1:0]  pred_ghr;
  logic              busy;
  logic              upd_valid;
  logic [31:0]       upd_pc;
  logic [GHR_W-1:0]  upd_ghr;
  logic              upd_taken;
  logic              upd_mispredict;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispredicts;
  modport master (
    output pred_req, pred_pc, pred_inst, upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
    input  pred_taken, pred_target, pred_ghr, busy, stat_branches, stat_mispredicts
  );
  modport slave (
    input  pred_req, pred_pc, pred_inst, upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
    output pred_taken, pred_target, pred_ghr, busy, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor_gshare.sv
// branch_predictor_gshare: gshare direction predictor with JAL targets, clear sweep and stats
module branch_predictor_gshare #(
  parameter int INDEX_W = 7,
  parameter int GHR_W   = 4,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 32
) (
  input logic clk,
  input logic rst,
  branch_predictor_gshare_if.slave bus
);
  typedef enum logic {CLEAR, RUN} state_e;
  state_e            state_q;
  logic [INDEX_W-1:0] clr_ptr_q;
  logic [CTR_W-1:0]  tbl_q [2**INDEX_W];
  logic [GHR_W-1:0]  ghr_q, ghr_d;
  logic [STAT_W-1:0] br_q, br_d, mp_q, mp_d;
  logic [INDEX_W-1:0] idx_p, idx_u;
  logic [CTR_W-1:0]  ctr_p, ctr_u, ctr_d;
  logic [31:0]       inst, imm_b, imm_j, seq;
  logic              run, jal, br;
  always_comb begin
    inst  = bus.pred_inst;
    run   = state_q == RUN;
    jal   = inst[6:0] == 7'b1101111;
    br    = inst[6:0] == 7'b1100011;
    imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    seq   = bus.pred_pc + 32'd4;
    idx_p = bus.pred_pc[INDEX_W+1:2] ^ INDEX_W'(ghr_q);
    idx_u = bus.upd_pc[INDEX_W+1:2] ^ INDEX_W'(bus.upd_ghr);
    ctr_p = tbl_q[idx_p];
    ctr_u = tbl_q[idx_u];
    ctr_d = bus.upd_taken ? (&ctr_u ? ctr_u : ctr_u + CTR_W'(1)) : (|ctr_u ? ctr_u - CTR_W'(1) : ctr_u);
    ghr_d = GHR_W'({ghr_q, bus.upd_taken});
    br_d  = &br_q ? br_q : br_q + STAT_W'(1);
    mp_d  = (&mp_q || !bus.upd_mispredict) ? mp_q : mp_q + STAT_W'(1);
  end
  assign bus.pred_taken       = bus.pred_req & run & (jal | (br & ctr_p[CTR_W-1]));
  assign bus.pred_target      = !bus.pred_req ? 32'd0 :
                                !run ? seq :
                                jal ? bus.pred_pc + imm_j :
                                bus.pred_taken ? bus.pred_pc + imm_b : seq;
  assign bus.pred_ghr         = ghr_q;
  assign bus.busy             = !run;
  assign bus.stat_branches    = br_q;
  assign bus.stat_mispredicts = mp_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      ghr_q     <= '0;
      br_q      <= '0;
      mp_q      <= '0;
    end else if (!run) begin
      tbl_q[clr_ptr_q] <= CTR_W'((1 << (CTR_W - 1)) - 1);
      clr_ptr_q        <= clr_ptr_q + INDEX_W'(1);
      if (&clr_ptr_q) state_q <= RUN;
    end else if (bus.upd_valid) begin
      tbl_q[idx_u] <= ctr_d;
      ghr_q        <= ghr_d;
      br_q         <= br_d;
      mp_q         <= mp_d;
    end
  end
endmodule
